// File: rtl/accum_sequencer.sv
// accum_sequencer: start/busy/done controller for a repeated-add accumulator.
// Optional macro ACCUM_SATURATE_EN clamps the sum at all ones instead of wrapping.
module accum_sequencer #(
    parameter int WIDTH     = 3,
    parameter int CNT_WIDTH = 3
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     num_in,
    input  logic [CNT_WIDTH-1:0] iterations,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic                 overflow,
    output logic [3:0]           disp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     operand;
    logic [WIDTH-1:0]     operand_nxt;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     acc_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 ovf;
    logic                 ovf_nxt;
    logic [WIDTH:0]       sum;

    // One extra bit keeps the carry-out of each addition.
    assign sum = {1'b0, acc} + {1'b0, operand};

    // State register; Reset also lands here mid-run.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers: operand, accumulator, counter, sticky carry.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            operand <= '0;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
        end else begin
            operand <= operand_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            ovf     <= ovf_nxt;
        end
    end

    // Next-state, next-datapath and handshake outputs.
    always_comb begin
        state_nxt   = state;
        operand_nxt = operand;
        acc_nxt     = acc;
        cnt_nxt     = cnt;
        ovf_nxt     = ovf;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state)
            IDLE: begin
                if (abort) begin
                    acc_nxt = '0;
                    ovf_nxt = 1'b0;
                end else if (start) begin
                    operand_nxt = num_in;
                    cnt_nxt     = iterations;
                    acc_nxt     = '0;
                    ovf_nxt     = 1'b0;
                    if (iterations == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                if (abort) begin
                    // Cancelled run: drop this edge's addition.
                    acc_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else begin
`ifdef ACCUM_SATURATE_EN
                    // Once clamped, any further add carries again or adds 0.
                    acc_nxt = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
                    acc_nxt = sum[WIDTH-1:0];
`endif
                    ovf_nxt = ovf | sum[WIDTH];
                    cnt_nxt = cnt - CNT_WIDTH'(1);
                    if (cnt == CNT_WIDTH'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign result   = acc;
    assign overflow = ovf;
    assign disp     = {ovf, acc[2:0]};

endmodule

// File: tb/tb_accum_sequencer.sv
// tb_accum_sequencer: directed and randomized checks of accum_sequencer
// against an arithmetic model of the accumulated sum.
module tb_accum_sequencer;

    localparam int W  = 3;
    localparam int CW = 3;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          start;
    logic          abort;
    logic [W-1:0]  num_in;
    logic [CW-1:0] iterations;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          overflow;
    logic [3:0]    disp;
    logic [W+6:0]  obs;

    int n_tests = 0;
    int n_fail  = 0;

    accum_sequencer #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .start      (start),
        .abort      (abort),
        .num_in     (num_in),
        .iterations (iterations),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .overflow   (overflow),
        .disp       (disp)
    );

    always #5 Clock = ~Clock;

    assign obs = {busy, done, overflow, result, disp};

    // Value after k additions of num: plain product, wrapped or clamped.
    function automatic void model(input int num, input int k,
                                  output int res, output bit ov);
        int tot;
        int mx;
        tot = num * k;
        mx  = (1 << W) - 1;
        ov  = (tot > mx);
`ifdef ACCUM_SATURATE_EN
        res = ov ? mx : tot;
`else
        res = tot % (mx + 1);
`endif
    endfunction

    // Expected {busy, done, overflow, result, disp}.
    function automatic logic [W+6:0] ev(input bit b, input bit d,
                                        input bit ov, input int res);
        logic [W-1:0] r;
        logic [3:0]   dd;
        r  = res[W-1:0];
        dd = {ov, r[2:0]};
        return {b, d, ov, r, dd};
    endfunction

    task automatic test_reset();
        logic [W+6:0] e;
        Reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        num_in = '0;
        iterations = '0;
        #12;
        n_tests++;
        if (obs !== ev(0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_init: got %h want %h", obs, ev(0, 0, 0, 0));
        end
        @(negedge Clock);
        Reset = 1'b0;
        start = 1'b1;
        num_in = 3'd3;
        iterations = 3'd7;
        @(negedge Clock);
        start = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        e = ev(1, 0, 0, 6);
        n_tests++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_prerun: got %h want %h", obs, e);
        end
        @(posedge Clock);
        #2;
        Reset = 1'b1;
        #1;
        n_tests++;
        if (obs !== ev(0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_async: got %h want %h", obs, ev(0, 0, 0, 0));
        end
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        n_tests++;
        if (obs !== ev(0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_idle: got %h want %h", obs, ev(0, 0, 0, 0));
        end
    endtask

    task automatic test_basic();
        logic [W+6:0] exp_q[$];
        exp_q = '{ev(1, 0, 0, 0), ev(1, 0, 0, 3),
                  ev(0, 1, 0, 6), ev(0, 0, 0, 6)};
        @(negedge Clock);
        start = 1'b1;
        num_in = 3'd3;
        iterations = 3'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            start = 1'b0;
            n_tests++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_c%0d: got %h want %h", i, obs, exp_q[i]);
            end
        end
        n_tests++;
        if (disp !== 4'h6) begin
            n_fail++;
            $display("FAIL basic_disp: got %h want 6", disp);
        end
    endtask

    task automatic test_wrap();
        logic [W+6:0] exp_q[$];
        logic [3:0]   d_exp;
`ifdef ACCUM_SATURATE_EN
        exp_q = '{ev(1, 0, 0, 0), ev(1, 0, 0, 5),
                  ev(0, 1, 1, 7), ev(0, 0, 1, 7)};
        d_exp = 4'hF;
`else
        exp_q = '{ev(1, 0, 0, 0), ev(1, 0, 0, 5),
                  ev(0, 1, 1, 2), ev(0, 0, 1, 2)};
        d_exp = 4'hA;
`endif
        @(negedge Clock);
        start = 1'b1;
        num_in = 3'd5;
        iterations = 3'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            start = 1'b0;
            n_tests++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL wrap_c%0d: got %h want %h", i, obs, exp_q[i]);
            end
        end
        n_tests++;
        if (disp !== d_exp) begin
            n_fail++;
            $display("FAIL wrap_disp: got %h want %h", disp, d_exp);
        end
    endtask

    task automatic test_zero();
        logic [W+6:0] exp_q[$];
        exp_q = '{ev(0, 1, 0, 0), ev(0, 0, 0, 0)};
        @(negedge Clock);
        start = 1'b1;
        num_in = 3'd7;
        iterations = 3'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clock);
            start = 1'b0;
            n_tests++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL zero_c%0d: got %h want %h", i, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_held_start();
        logic [W+6:0] e;
        @(negedge Clock);
        start = 1'b1;
        num_in = 3'd1;
        iterations = 3'd7;
        for (int j = 0; j < 7; j++) begin
            @(negedge Clock);
            if (j == 3) begin
                num_in = 3'd6;
                iterations = 3'd2;
            end
            e = ev(1, 0, 0, j);
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL held_run%0d: got %h want %h", j, obs, e);
            end
        end
        @(negedge Clock);
        n_tests++;
        if (obs !== ev(0, 1, 0, 7)) begin
            n_fail++;
            $display("FAIL held_done: got %h want %h", obs, ev(0, 1, 0, 7));
        end
        @(negedge Clock);
        n_tests++;
        if (obs !== ev(0, 0, 0, 7)) begin
            n_fail++;
            $display("FAIL held_idle: got %h want %h", obs, ev(0, 0, 0, 7));
        end
        @(negedge Clock);
        n_tests++;
        if (obs !== ev(1, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL held_rerun: got %h want %h", obs, ev(1, 0, 0, 0));
        end
        start = 1'b0;
        abort = 1'b1;
        @(negedge Clock);
        abort = 1'b0;
        n_tests++;
        if (obs !== ev(0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL held_abort: got %h want %h", obs, ev(0, 0, 0, 0));
        end
    endtask

    task automatic test_abort();
        logic [W+6:0] e;
        int           r;
        bit           o;
        @(negedge Clock);
        start = 1'b1;
        num_in = 3'd2;
        iterations = 3'd5;
        for (int j = 0; j < 3; j++) begin
            @(negedge Clock);
            start = 1'b0;
            e = ev(1, 0, 0, 2 * j);
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL abort_run%0d: got %h want %h", j, obs, e);
            end
        end
        abort = 1'b1;
        @(negedge Clock);
        abort = 1'b0;
        for (int j = 0; j < 4; j++) begin
            n_tests++;
            if (obs !== ev(0, 0, 0, 0)) begin
                n_fail++;
                $display("FAIL abort_idle%0d: got %h want %h",
                         j, obs, ev(0, 0, 0, 0));
            end
            @(negedge Clock);
        end
        start = 1'b1;
        num_in = 3'd5;
        iterations = 3'd2;
        @(negedge Clock);
        start = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        @(negedge Clock);
        model(5, 2, r, o);
        e = ev(0, 0, o, r);
        n_tests++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL abort_pre: got %h want %h", obs, e);
        end
        start = 1'b1;
        abort = 1'b1;
        num_in = 3'd3;
        iterations = 3'd2;
        for (int j = 0; j < 2; j++) begin
            @(negedge Clock);
            start = 1'b0;
            abort = 1'b0;
            n_tests++;
            if (obs !== ev(0, 0, 0, 0)) begin
                n_fail++;
                $display("FAIL abort_start%0d: got %h want %h",
                         j, obs, ev(0, 0, 0, 0));
            end
        end
    endtask

    task automatic test_random();
        logic [W+6:0] e;
        int           num;
        int           n;
        int           r;
        bit           o;
        @(negedge Clock);
        for (int it = 0; it < 30; it++) begin
            num = $urandom_range(0, 7);
            n   = $urandom_range(0, 7);
            start = 1'b1;
            abort = 1'b0;
            num_in = num[W-1:0];
            iterations = n[CW-1:0];
            for (int j = 0; j < n; j++) begin
                @(negedge Clock);
                start = 1'($urandom_range(0, 1));
                num_in = W'($urandom_range(0, 7));
                iterations = CW'($urandom_range(0, 7));
                model(num, j, r, o);
                e = ev(1, 0, o, r);
                n_tests++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL rand%0d_run%0d: got %h want %h",
                             it, j, obs, e);
                end
            end
            @(negedge Clock);
            start = 1'($urandom_range(0, 1));
            model(num, n, r, o);
            e = ev(0, 1, o, r);
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL rand%0d_done: got %h want %h", it, obs, e);
            end
            @(negedge Clock);
            e = ev(0, 0, o, r);
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL rand%0d_idle: got %h want %h", it, obs, e);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero();
        test_held_start();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
